// File: rtl/linebuf_pixreader_pkg.sv
// linebuf_pixreader_pkg
//   Shared constants for the line-buffer pixel reader: FSM state encodings,
//   fixed foreground/background colours and the bit-to-colour mapping.
package linebuf_pixreader_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_PRIME  = 2'b01;
    localparam logic [1:0] ST_ACTIVE = 2'b10;

    // Yellow for set bits, dark purple for clear bits.
    localparam logic [3:0] FG_RED   = 4'hF;
    localparam logic [3:0] FG_GREEN = 4'hF;
    localparam logic [3:0] FG_BLUE  = 4'h0;
    localparam logic [3:0] BG_RED   = 4'h2;
    localparam logic [3:0] BG_GREEN = 4'h0;
    localparam logic [3:0] BG_BLUE  = 4'h8;

    // Returns {red, green, blue} for one pixel bit.
    function automatic logic [11:0] pix_colour(input logic bit_val);
        return bit_val ? {FG_RED, FG_GREEN, FG_BLUE} : {BG_RED, BG_GREEN, BG_BLUE};
    endfunction

endpackage

// File: rtl/linebuf_pixreader.sv
// linebuf_pixreader
//   Read side of the 256x16 line buffer RAM. On each visible line it fetches
//   WORDS_PER_LINE words starting at line_base and shifts them out MSB-first,
//   one bit per pixel, mapping each bit to a fixed FG/BG colour.
//
// Ports
//   clk              PLL clock, all flops on posedge
//   nrst             synchronous active-low reset
//   pix_en           pixel-rate strobe (one clk wide, >= 2 clks apart)
//   line_start       start-of-line pulse, honoured only together with pix_en
//   line_base        RAM word address of the line's first word
//   linebuf_rd       RAM read clock enable, one-cycle pulse per word fetch
//   linebuf_rd_addr  RAM read address, held between fetches
//   linebuf_rd_data  RAM read data, valid from the 2nd clk after a read pulse
//   red/green/blue   registered pixel colour, 0 when not active
//   active           high while visible pixels are being driven
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no line in progress, RGB held at 0
// ST_PRIME  | first word requested, waiting for the pix_en that shows it
// ST_ACTIVE | shifting pixels out, prefetching one word ahead
module linebuf_pixreader
    import linebuf_pixreader_pkg::*;
#(
    parameter int WORDS_PER_LINE = 50
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        pix_en,
    input  logic        line_start,
    input  logic [7:0]  line_base,
    output logic        linebuf_rd,
    output logic [7:0]  linebuf_rd_addr,
    input  logic [15:0] linebuf_rd_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        active
);

    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);

    logic [1:0]  state;
    logic [15:0] shift;
    logic [7:0]  word_cnt;
    logic [3:0]  bit_idx;
    logic [11:0] rgb;

    assign {red, green, blue} = rgb;

    // shift holds the bits still to be shown, already advanced past the pixel
    // currently on RGB; bit_idx is the in-word index of the next pixel. When
    // bit_idx is 0 the next pixel comes straight from the RAM output, which
    // acts as the holding register for the prefetched word.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state           <= ST_IDLE;
            shift           <= '0;
            word_cnt        <= '0;
            bit_idx         <= '0;
            rgb             <= '0;
            active          <= 1'b0;
            linebuf_rd      <= 1'b0;
            linebuf_rd_addr <= '0;
        end else begin
            linebuf_rd <= 1'b0;
            if (pix_en && line_start) begin
                // Start or abort-and-restart a line from any state.
                state           <= ST_PRIME;
                linebuf_rd      <= 1'b1;
                linebuf_rd_addr <= line_base;
                word_cnt        <= '0;
                bit_idx         <= '0;
                rgb             <= '0;
                active          <= 1'b0;
            end else if (pix_en) begin
                case (state)
                    ST_PRIME: begin
                        state   <= ST_ACTIVE;
                        active  <= 1'b1;
                        rgb     <= pix_colour(linebuf_rd_data[15]);
                        shift   <= {linebuf_rd_data[14:0], 1'b0};
                        bit_idx <= 4'd1;
                        if (LAST_WORD != 8'd0) begin
                            linebuf_rd      <= 1'b1;
                            linebuf_rd_addr <= linebuf_rd_addr + 8'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (bit_idx == 4'd0) begin
                            if (word_cnt == LAST_WORD) begin
                                state  <= ST_IDLE;
                                rgb    <= '0;
                                active <= 1'b0;
                            end else begin
                                word_cnt <= word_cnt + 8'd1;
                                rgb      <= pix_colour(linebuf_rd_data[15]);
                                shift    <= {linebuf_rd_data[14:0], 1'b0};
                                bit_idx  <= 4'd1;
                                if ((word_cnt + 8'd1) < LAST_WORD) begin
                                    linebuf_rd      <= 1'b1;
                                    linebuf_rd_addr <= linebuf_rd_addr + 8'd1;
                                end
                            end
                        end else begin
                            rgb     <= pix_colour(shift[15]);
                            shift   <= {shift[14:0], 1'b0};
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    default: begin
                        rgb    <= '0;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_linebuf_pixreader.sv
module tb_linebuf_pixreader;

    localparam int WPL = 50;
    localparam logic [11:0] FG = 12'hFF0;
    localparam logic [11:0] BG = 12'h208;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pix_en = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  line_base = 8'h00;
    logic        linebuf_rd;
    logic [7:0]  linebuf_rd_addr;
    logic [15:0] linebuf_rd_data;
    logic [3:0]  red, green, blue;
    logic        active;

    always #5 clk = ~clk;

    linebuf_pixreader #(.WORDS_PER_LINE(WPL)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .pix_en          (pix_en),
        .line_start      (line_start),
        .line_base       (line_base),
        .linebuf_rd      (linebuf_rd),
        .linebuf_rd_addr (linebuf_rd_addr),
        .linebuf_rd_data (linebuf_rd_data),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .active          (active)
    );

    // Registered-read, RCLKE-gated RAM model.
    logic [15:0] mem [256];
    logic [15:0] ram_q = 16'h0000;
    always @(posedge clk) if (linebuf_rd) ram_q <= mem[linebuf_rd_addr];
    assign linebuf_rd_data = ram_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a line is a list of WPL*16 pixels read from mem
    // starting at base; pixel n shows on the (n+1)th pix_en after the
    // line_start edge. Word j+1 is fetched when pixel 16*j is shown.
    bit          in_line = 1'b0;
    int          k = 0;
    logic [7:0]  base = 8'h00;
    logic [7:0]  exp_addr = 8'h00;
    logic        exp_rd = 1'b0;
    logic        exp_act = 1'b0;
    logic [11:0] exp_rgb = 12'h000;
    int          rd_seen = 0;
    int          pe_cnt = 0;
    int          gap = 2;
    bit          spurious = 1'b0;

    task automatic cycle();
        bit pe, ls, rn;
        logic [7:0] lb;
        logic [15:0] w;
        int n;
        pe = pix_en; ls = line_start; rn = nrst; lb = line_base;
        @(posedge clk);
        #1;
        exp_rd = 1'b0;
        if (!rn) begin
            in_line = 1'b0; exp_addr = 8'h00; exp_rgb = 12'h000; exp_act = 1'b0;
        end else if (pe && ls) begin
            in_line = 1'b1; k = 0; base = lb;
            exp_rd = 1'b1; exp_addr = lb; exp_rgb = 12'h000; exp_act = 1'b0;
        end else if (pe && in_line) begin
            k++;
            n = k - 1;
            if (n < WPL * 16) begin
                w = mem[8'(int'(base) + n / 16)];
                exp_act = 1'b1;
                exp_rgb = w[15 - n % 16] ? FG : BG;
                if (n % 16 == 0 && n / 16 < WPL - 1) begin
                    exp_rd = 1'b1;
                    exp_addr = 8'(int'(base) + n / 16 + 1);
                end
            end else begin
                in_line = 1'b0; exp_act = 1'b0; exp_rgb = 12'h000;
            end
        end
        if (linebuf_rd) rd_seen++;
        chk("rd",      16'(linebuf_rd),          16'(exp_rd));
        chk("rd_addr", 16'(linebuf_rd_addr),     16'(exp_addr));
        chk("active",  16'(active),              16'(exp_act));
        chk("rgb",     16'({red, green, blue}),  16'(exp_rgb));
    endtask

    task automatic tick();
        pix_en = (pe_cnt == 0);
        pe_cnt = (pe_cnt + 1 >= gap) ? 0 : pe_cnt + 1;
        if (spurious && !pix_en && $urandom_range(0, 15) == 0) line_start = 1'b1;
        cycle();
        line_start = 1'b0;
        line_base = 8'($urandom);
    endtask

    task automatic start_line(input logic [7:0] b);
        while (pe_cnt != 0) tick();
        rd_seen = 0;
        line_base = b;
        line_start = 1'b1;
        tick();
    endtask

    task automatic finish_line();
        int guard;
        guard = 0;
        while (in_line && guard < 5000) begin
            tick();
            guard++;
        end
        chk("line_timeout", 16'(guard < 5000), 16'd1);
        repeat (6) tick();
        chk("rd_count", 16'(rd_seen), 16'(WPL));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;

        // reset state
        nrst = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
        repeat (5) tick();

        // pattern at base 0, fetch sequence, wrap
        start_line(8'h00); finish_line();
        start_line(8'h10); finish_line();
        start_line(8'hF0); finish_line();

        // reset mid-line, then no reads until the next line_start
        start_line(8'($urandom));
        repeat (600) tick();
        nrst = 1'b0;
        repeat (4) tick();
        nrst = 1'b1;
        repeat (40) tick();
        start_line(8'($urandom)); finish_line();

        // restart at pixel 300
        start_line(8'($urandom));
        begin
            int guard;
            guard = 0;
            while (k < 300 && guard < 2000) begin
                tick();
                guard++;
            end
            chk("restart_timeout", 16'(guard < 2000), 16'd1);
        end
        start_line(8'h80); finish_line();

        // random bases, pixel gaps and ignored line_start pulses
        spurious = 1'b1;
        for (int l = 0; l < 4; l++) begin
            gap = int'($urandom_range(2, 3));
            start_line(8'($urandom));
            finish_line();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
